aes_decrypt_core: RTL and testbench
===================================

# aes_decrypt_core

Iterative AES-128 inverse cipher, the decryption counterpart to the encryption datapath. It takes a 128-bit cipher key and expands it forward once to the last round key. Each 128-bit ciphertext then takes ten cycles, one inverse round per cycle, with round keys regenerated in reverse on the fly. An internal FSM owns sequencing, so the block needs no external controller and sits directly between the testbench or host and any consumer of plaintext.

## Interface
- Parameters: none. AES-128 only, Nr = 10, fixed in package.
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- key_load  in  1  pulse; sample cipher_key and start forward key expansion
- cipher_key  in  128  cipher key, byte 0 in bits [127:120]
- key_ready  out  1  last round key K10 valid; decryption permitted
- start  in  1  pulse; sample cipher_text and begin decryption
- cipher_text  in  128  ciphertext block, same byte order
- busy  out  1  decryption in progress
- done  out  1  one-cycle pulse; plain_text valid
- plain_text  out  128  registered result, held until the next done

## Operation
- FSM states: IDLE, KEXP, DEC. Counter rnd is 4 bits, range 1..10.
- Reset values: state IDLE, rnd 0, key_ready 0, busy 0, done 0, plain_text 0, all key and state registers 0.
- **IDLE + key_load:**
  - Capture cipher_key into key_reg.
  - Clear key_ready.
  - Set rnd = 1 and go to KEXP.
- **KEXP, each cycle:**
  - key_reg <= forward schedule(key_reg, Rcon[rnd]), with Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - When rnd = 10: set key_ready, store key_reg in k10_reg, go to IDLE.
- **key_load during KEXP:** restart with the new key, rnd = 1.
- **IDLE + start + key_ready + !key_load:**
  - state <= cipher_text ^ k10_reg.
  - rk <= k10_reg.
  - rnd = 1, busy = 1, go to DEC.
- **DEC, cycle for round r:**
  - rk_prev = inverse schedule(rk, Rcon[11-r]):
    - w3' = w3 ^ w2
    - w2' = w2 ^ w1
    - w1' = w1 ^ w0
    - w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon
  - r < 10: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_prev).
  - r = 10: plain_text <= InvSubBytes(InvShiftRows(state)) ^ rk_prev. Then done = 1, busy = 0, go to IDLE.
  - rk <= rk_prev, rnd++.
- **Inputs that are ignored:**
  - start while key_ready = 0, or while in KEXP or DEC.
  - key_load while in DEC. The current decryption completes with the old key.
- Simultaneous key_load and start in IDLE: key_load wins and start is dropped.
- k10_reg persists across decryptions. Repeated starts need no re-expansion.
- Reset mid-KEXP or mid-DEC: return to IDLE immediately. key_ready = 0, no done pulse, plain_text = 0.

## Timing
- Key expansion: key_load sampled at edge E0; key_ready rises after edge E10. The key is usable by a start sampled at edge E11 or later.
- Decrypt latency: start sampled at edge T0; done and the new plain_text are visible after edge T10, i.e. 10 cycles.
- busy is high after edge T0 through edge T10.
- Back-to-back: a start asserted in the done cycle is accepted, giving a throughput of one block per 11 cycles.
- done is high for exactly one cycle. plain_text is stable from done until the next done or reset.

## Structure
- Package aes_dec_pkg holds:
  - Nr = 10
  - the Rcon table
  - the FSM state enum
  - functions sbox, inv_sbox, xtime/gmul, inv_mix_column (32-bit), and rot_word/sub_word.
- Sub-module aes_inv_round: combinational inverse round. It is parameterless, with a last_round input that bypasses InvMixColumns. Inputs are state and rk_prev; output is next_state.
- The forward and inverse key-schedule steps are package functions shared by the KEXP and DEC paths.

## Test plan
- FIPS-197 App. C.1:
  - Load key 000102030405060708090a0b0c0d0e0f. key_ready rises 10 cycles later and k10 = 13111d7fe3944a17f307a78b4d2b30c5.
  - Decrypt ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, done exactly 10 cycles after start.
- FIPS-197 App. B:
  - Load key 2b7e151628aed2a6abf7158809cf4f3c, giving k10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Decrypt ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
- Back-to-back: with the App. B key, assert start again in the done cycle with the App. C.1 ct. The second result is correct only if k10 was reused with no reload; compare against an encrypt-side reference.
- Ignored and priority cases:
  - start before key_ready -> no busy, no done.
  - start during DEC -> no effect.
  - key_load and start in the same IDLE cycle -> KEXP entered, no decryption.
- Reset at cycle 5 of DEC: all outputs return to 0 asynchronously and no done follows. After re-loading the key, the C.1 vector passes.
- Round trip: 100 random key/pt pairs encrypted by the encryption core, then decrypted here -> pt matches exactly.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared AES-128 definitions for the inverse cipher: the round count, the Rcon
// table, the FSM states, the S-boxes, GF(2^8) helpers and the two key-schedule steps.
package aes_dec_pkg;

  localparam int Nr = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEXP = 2'd1,
    DEC  = 2'd2
  } state_t;

  // Rcon[1] in the top byte down to Rcon[10] in the bottom byte
  localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

  // Forward S-box, entry 0 in the top byte
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box, entry 0 in the top byte
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Rcon lookup for indices 1..10; anything else yields zero
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    if (idx >= 4'd1 && idx <= 4'd10) r = RCON_TBL[8*(10 - int'(idx)) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[8*(255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[8*(255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply; with a constant b this folds into a few XORs
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // One column of InvMixColumns, row 0 in the top byte
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round key r -> round key r+1
  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Round key r -> round key r-1; rc is the Rcon that produced k
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n3 = k[31:0] ^ k[63:32];
    n2 = k[63:32] ^ k[95:64];
    n1 = k[95:64] ^ k[127:96];
    n0 = k[127:96] ^ sub_word(rot_word(n3)) ^ {rc, 24'h000000};
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// except on the final round, InvMixColumns. Byte 0 sits in bits [127:120].
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rkPrev,
  input  logic         lastRound,
  output logic [127:0] nextState
);

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] added;
  logic [127:0] mixed;

  // Row r rotates right by r columns; byte index is 4*column + row
  always_comb begin
    shifted = '0;
    subbed  = '0;
    mixed   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127 - 8*(4*c + r) -: 8] = state[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    for (int b = 0; b < 16; b++) begin
      subbed[127 - 8*b -: 8] = inv_sbox(shifted[127 - 8*b -: 8]);
    end
    added = subbed ^ rkPrev;
    for (int c = 0; c < 4; c++) begin
      mixed[127 - 32*c -: 32] = inv_mix_column(added[127 - 32*c -: 32]);
    end
    nextState = lastRound ? added : mixed;
  end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor. A key load runs the forward schedule once to
// capture K10; each block then takes ten inverse rounds, one per cycle, with
// round keys walked backwards from K10 on the fly.
module aes_decrypt_core
  import aes_dec_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         key_load,
  input  logic [127:0] cipher_key,
  output logic         key_ready,
  input  logic         start,
  input  logic [127:0] cipher_text,
  output logic         busy,
  output logic         done,
  output logic [127:0] plain_text
);

  state_t       st;
  logic [3:0]   rnd;
  logic [127:0] keyReg;
  logic [127:0] k10Reg;
  logic [127:0] rk;
  logic [127:0] stateReg;
  logic [127:0] fwdKey;
  logic [127:0] rkPrev;
  logic [127:0] roundOut;
  logic         lastRound;

  // Next forward key during expansion, previous round key during decryption
  always_comb begin
    fwdKey    = key_fwd(keyReg, rcon(rnd));
    rkPrev    = key_inv(rk, rcon(4'd11 - rnd));
    lastRound = (rnd == 4'(Nr));
  end

  aes_inv_round uRound (
    .state     (stateReg),
    .rkPrev    (rkPrev),
    .lastRound (lastRound),
    .nextState (roundOut)
  );

  // Sequencer: key expansion, round iteration and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st         <= IDLE;
      rnd        <= 4'd0;
      keyReg     <= '0;
      k10Reg     <= '0;
      rk         <= '0;
      stateReg   <= '0;
      key_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      plain_text <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: begin
          if (key_load) begin
            // a key load takes priority over a simultaneous start
            keyReg    <= cipher_key;
            key_ready <= 1'b0;
            rnd       <= 4'd1;
            st        <= KEXP;
          end else if (start && key_ready) begin
            stateReg <= cipher_text ^ k10Reg;
            rk       <= k10Reg;
            rnd      <= 4'd1;
            busy     <= 1'b1;
            st       <= DEC;
          end
        end
        KEXP: begin
          if (key_load) begin
            keyReg <= cipher_key;
            rnd    <= 4'd1;
          end else begin
            keyReg <= fwdKey;
            if (rnd == 4'(Nr)) begin
              k10Reg    <= fwdKey;
              key_ready <= 1'b1;
              st        <= IDLE;
            end else begin
              rnd <= rnd + 4'd1;
            end
          end
        end
        DEC: begin
          // key_load and start are ignored until the block completes
          rk  <= rkPrev;
          rnd <= rnd + 4'd1;
          if (lastRound) begin
            plain_text <= roundOut;
            done       <= 1'b1;
            busy       <= 1'b0;
            st         <= IDLE;
          end else begin
            stateReg <= roundOut;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Bench for aes_decrypt_core: FIPS-197 vectors, control corner cases, an
// asynchronous reset mid-block and a round trip through an AES-128 encryptor.
module tb_aes_decrypt_core;

  logic         clk;
  logic         rstn;
  logic         key_load;
  logic [127:0] cipher_key;
  logic         key_ready;
  logic         start;
  logic [127:0] cipher_text;
  logic         busy;
  logic         done;
  logic [127:0] plain_text;

  aes_decrypt_core dut (
    .clk         (clk),
    .rstn        (rstn),
    .key_load    (key_load),
    .cipher_key  (cipher_key),
    .key_ready   (key_ready),
    .start       (start),
    .cipher_text (cipher_text),
    .busy        (busy),
    .done        (done),
    .plain_text  (plain_text)
  );

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  typedef struct {
    logic [127:0] expVal;
    logic [127:0] keyVal;
    bit           viaEnc;
    int           due;
    string        name;
  } exp_t;

  exp_t         sbq[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  logic [7:0]   sb[256];
  logic [127:0] lastPt;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map
  function automatic logic [7:0] sboxCalc(input logic [7:0] v);
    logic [7:0] inv;
    logic [7:0] e;
    inv = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      inv = gm(inv, inv);
      if (e[i]) inv = gm(inv, v);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Reference AES-128 encryption
  function automatic logic [127:0] aesEnc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w[44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127 - 8*b -: 8] ^ w[b/4][31 - 8*(b%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sb[s[b]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c + row] = t[4*((c + row) % 4) + row];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31 - 8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = s[b];
    return res;
  endfunction

  // Pops the oldest expectation whenever done is seen
  task automatic monitor();
    exp_t         e;
    logic [127:0] act;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 128'(cyc), 128'(-1));
        end else begin
          e = sbq.pop_front();
          act = e.viaEnc ? aesEnc(e.keyVal, plain_text) : plain_text;
          chk({e.name, "_data"}, act, e.expVal);
          chk({e.name, "_latency"}, 128'(cyc), 128'(e.due));
        end
      end
    end
  endtask

  // Caller must be away from the rising edge
  task automatic doStart(input logic [127:0] ct, input bit accept, input logic [127:0] expVal,
                         input logic [127:0] keyVal, input bit viaEnc, input string nm);
    exp_t e;
    start = 1'b1;
    cipher_text = ct;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (accept) begin
      e.expVal = expVal;
      e.keyVal = keyVal;
      e.viaEnc = viaEnc;
      e.due    = cyc + 10;
      e.name   = nm;
      sbq.push_back(e);
      chk({nm, "_busy"}, 128'(busy), 128'(1));
    end
  endtask

  task automatic loadKey(input logic [127:0] key, input bit withStart, input logic [127:0] ct);
    int lat;
    @(negedge clk);
    key_load = 1'b1;
    cipher_key = key;
    start = withStart;
    cipher_text = ct;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    start = 1'b0;
    chk("key_ready_cleared", 128'(key_ready), 128'(0));
    if (withStart) chk("kl_start_no_busy", 128'(busy), 128'(0));
    lat = 0;
    while (key_ready !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("key_ready_latency", 128'(lat), 128'(10));
  endtask

  task automatic waitDone(input int maxCyc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 128'(got), 128'(1));
  endtask

  initial begin
    logic [127:0] rk;
    logic [127:0] rp;
    logic [127:0] rc;
    bit           sawBusy;

    for (int i = 0; i < 256; i++) sb[i] = sboxCalc(8'(i));
    rstn = 1'b0;
    key_load = 1'b0;
    cipher_key = '0;
    start = 1'b0;
    cipher_text = '0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_key_ready", 128'(key_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_plain_text", plain_text, 128'(0));

    // start with no key loaded is dropped
    start = 1'b1;
    cipher_text = CT_C1;
    sawBusy = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy === 1'b1) sawBusy = 1'b1;
    end
    chk("nokey_start_busy", 128'(sawBusy), 128'(0));

    // FIPS-197 C.1, with a stray start mid-block
    loadKey(KEY_C1, 1'b0, '0);
    @(negedge clk);
    doStart(CT_C1, 1'b1, PT_C1, '0, 1'b0, "c1");
    repeat (3) @(negedge clk);
    doStart(CT_B, 1'b0, '0, '0, 1'b0, "ignored");
    chk("dec_start_busy", 128'(busy), 128'(1));
    waitDone(20);
    repeat (12) @(negedge clk);

    // key_load and start together: load wins, key becomes App. B
    loadKey(KEY_B, 1'b1, CT_B);
    @(negedge clk);
    doStart(CT_B, 1'b1, PT_B, '0, 1'b0, "appb");
    waitDone(20);
    // back-to-back in the done cycle, reusing K10 of the App. B key
    doStart(CT_C1, 1'b1, CT_C1, KEY_B, 1'b1, "b2b");
    waitDone(20);
    repeat (3) @(negedge clk);

    // asynchronous reset in the fifth decrypt cycle
    doStart(CT_B, 1'b0, '0, '0, 1'b0, "rst_dec");
    repeat (5) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_key_ready", 128'(key_ready), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_done", 128'(done), 128'(0));
    chk("arst_plain_text", plain_text, 128'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (15) @(negedge clk);
    loadKey(KEY_C1, 1'b0, '0);
    @(negedge clk);
    doStart(CT_C1, 1'b1, PT_C1, '0, 1'b0, "c1_after_rst");
    waitDone(20);

    // random round trip
    for (int n = 0; n < 100; n++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      rp = {$urandom(), $urandom(), $urandom(), $urandom()};
      rc = aesEnc(rk, rp);
      loadKey(rk, 1'b0, '0);
      @(negedge clk);
      doStart(rc, 1'b1, rp, '0, 1'b0, "rand");
      waitDone(20);
      lastPt = rp;
    end

    repeat (5) @(negedge clk);
    chk("pt_hold", plain_text, lastPt);
    chk("queue_drained", 128'(sbq.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
